// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter that owns the select lines of a shared 4:1 single-bit mux.
// Optional forced-handoff timeout is compiled in with `define MUX4_ARB_TIMEOUT_EN.
`default_nettype none

module mux4_rr_arbiter #(
  parameter int HOLD_MAX = 4,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] d,
  output logic [3:0] grant,
  output logic [1:0] select,
  output logic       q,
  output logic       busy
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_grant, w_grant_nxt;
  logic [1:0]       r_sel, w_sel_nxt;
  logic             r_q, w_q_nxt;

  // Returns {found, index}: first set bit of r scanning upward from p with wrap.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] k;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      k = p + 2'(i);
      if (r[k]) res = {1'b1, k};
    end
    return res;
  endfunction

  logic [3:0] w_others;
  logic [1:0] w_hand_ptr;
  logic [2:0] w_pick_idle;
  logic [2:0] w_pick_hand;
  logic       w_cnt_top;
  logic       w_force;
  logic       w_cnt_clr;

  assign w_others    = req & ~(4'b0001 << r_sel);
  assign w_hand_ptr  = r_sel + 2'd1;
  assign w_pick_idle = rr_pick(req, r_ptr);
  assign w_pick_hand = rr_pick(w_others, w_hand_ptr);
  assign w_cnt_top   = (r_cnt == CNT_W'(HOLD_MAX - 1));

`ifdef MUX4_ARB_TIMEOUT_EN
  assign w_force   = w_cnt_top && req[r_sel] && (|w_others);
  assign w_cnt_clr = w_cnt_top;
`else
  assign w_force   = 1'b0;
  assign w_cnt_clr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ptr   <= 2'd0;
      r_cnt   <= '0;
      r_grant <= 4'b0000;
      r_sel   <= 2'd0;
      r_q     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_grant <= w_grant_nxt;
      r_sel   <= w_sel_nxt;
      r_q     <= w_q_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_grant_nxt = r_grant;
    w_sel_nxt   = r_sel;
    w_q_nxt     = r_q;
    case (r_state)
      S_IDLE: begin
        w_q_nxt     = 1'b0;
        w_grant_nxt = 4'b0000;
        if (w_pick_idle[2]) begin
          w_state_nxt = S_GRANT;
          w_grant_nxt = 4'b0001 << w_pick_idle[1:0];
          w_sel_nxt   = w_pick_idle[1:0];
          w_cnt_nxt   = '0;
        end
      end
      S_GRANT: begin
        w_q_nxt = d[r_sel];
        // Release and forced handoff share one path: the outgoing owner is masked.
        if (!req[r_sel] || w_force) begin
          w_ptr_nxt = w_hand_ptr;
          w_cnt_nxt = '0;
          if (w_pick_hand[2]) begin
            w_grant_nxt = 4'b0001 << w_pick_hand[1:0];
            w_sel_nxt   = w_pick_hand[1:0];
          end else begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = 4'b0000;
            w_q_nxt     = 1'b0;
          end
        end else if (w_cnt_clr) begin
          w_cnt_nxt = '0;
        end else if (!w_cnt_top) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = 4'b0000;
        w_q_nxt     = 1'b0;
      end
    endcase
  end

  assign grant  = r_grant;
  assign select = r_sel;
  assign q      = r_q;
  assign busy   = (r_state == S_GRANT);

endmodule

`default_nettype wire

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared 4:1 single-bit mux channel.
- Four requesters each own one mux data input (d[i]). The block grants the channel to one requester at a time and drives the 2-bit mux select.
- It registers the selected bit as the channel output.
- It sits in front of the 4:1 mux datapath and owns its select lines.

Parameters:
- HOLD_MAX, 4, maximum consecutive grant cycles before a forced handoff (only used when the timeout feature is compiled in); legal 2..16.
- CNT_W, 4, hold-counter width; must satisfy 2^CNT_W >= HOLD_MAX.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  4  request, one bit per requester; level-sensitive, held while the requester wants the channel.
- d  input  4  data bit from each requester (mux data inputs).
- grant  output  4  one-hot grant, registered; all zero when idle.
- select  output  2  mux select, registered; index of the granted requester.
- q  output  1  registered channel output.
- busy  output  1  high while in GRANT.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset): sampled on the clk rising edge only.
- Reset values: grant=0000, select=00, q=0, busy=0, state=IDLE, rr pointer ptr=0, hold counter cnt=0. Reset asserted mid-grant wins over all other events; the grant drops on that same edge.
- Registers: state {IDLE, GRANT}, ptr[1:0] = highest-priority index for the next arbitration, cnt[CNT_W-1:0].
- Arbitration function: scan req starting at index ptr, wrapping 3->0, and pick the first set bit. Example: ptr=2 scans 2,3,0,1.
- IDLE:
  - req==0000: stay in IDLE; grant=0, busy=0, select holds its last value, q=0.
  - Any req set: next edge -> GRANT. grant=onehot(win), select=win, busy=1, cnt=0. Latency is 1 cycle from req to grant.
- GRANT (owner index g = select):
  - Every cycle: q <= d[g]. q lags d by exactly 1 cycle.
  - req[g]=1 and no forced handoff: hold the grant, cnt <= cnt+1, saturating at HOLD_MAX-1.
  - req[g]=0 (release): set ptr <= g+1 mod 4 and rearbitrate the same cycle over req with bit g masked.
    - Another requester found: direct handoff with no dead cycle. grant/select switch on the next edge, cnt=0.
    - None found: -> IDLE, grant=0, busy=0, q=0 on the next edge.
- Simultaneous requests: the round-robin order strictly decides. A requester that just released cannot win again until all other active requesters have been served once.
- Glitch-free requirement: grant is always one-hot or zero. select changes only on an edge where grant changes.
- The block never inspects d apart from q; the data value has no effect on arbitration.

Optional Feature:
- Macro: MUX4_ARB_TIMEOUT_EN.
- With the macro defined:
  - In GRANT, if cnt==HOLD_MAX-1, req[g]=1 and at least one other req is set, this is a forced handoff. It behaves exactly like a release: ptr <= g+1, rearbitrate with g masked, new owner on the next edge, cnt=0.
  - If no other req is set, the grant is kept and cnt resets to 0.
- Without the macro: there is no timeout. An owner keeps the grant until it drops req. cnt may be removed, and HOLD_MAX/CNT_W are ignored.

Test Plan:
- Reset: assert reset 2 cycles with req=1111 -> grant=0000, select=00, q=0, busy=0 throughout. Deassert -> next edge grant=0001, select=00, busy=1.
- Single requester: req=0100 for 3 cycles then 0000, with d=0100 then d=0000 -> grant=0100, select=10. q=1 one cycle after grant, q follows d[2] with 1-cycle lag. After release, IDLE with grant=0000 and q=0.
- Round robin: req=1111 held, each owner drops its req bit for one cycle after 2 cycles of ownership -> grant sequence 0001,0010,0100,1000,0001 with no idle cycle between owners.
- Wrap and fairness: ptr=3 state (last owner 2), then req=1001 -> grant=1000 first. On release, grant=0001.
- Timeout (MUX4_ARB_TIMEOUT_EN, HOLD_MAX=4): req=0011 constant -> grant alternates 0001 x4 cycles, 0010 x4 cycles, repeating. With req=0001 only, grant=0001 held indefinitely.
- Reset mid-grant: owner 1 active, assert reset -> next edge grant=0000, ptr=0. After release with req=0110, grant=0010.
